// File: rtl/apb_pkg.sv
// Shared definitions for the parameterised APB requester.
package apb_pkg;

   // Transfer phases of the requester FSM.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Ceiling log2; returns 0 for inputs 0 and 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p << 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Turns a completer index into a one-hot select, flagging indices with no completer.
module apb_addr_decoder #(
   parameter int unsigned NUM_SLV = 2,
   parameter int unsigned SEL_W   = 1
) (
   input  logic [SEL_W-1:0]   i_idx,
   output logic [NUM_SLV-1:0] o_psel,
   output logic               o_dec_err
);

   // One-hot decode; any index without a matching completer is a decode error.
   always_comb begin
      o_psel    = '0;
      o_dec_err = 1'b1;
      for (int k = 0; k < NUM_SLV; k++) begin
         if (i_idx == SEL_W'(k)) begin
            o_psel[k] = 1'b1;
            o_dec_err = 1'b0;
         end
      end
   end

endmodule

// File: rtl/apb_param_master.sv
// Single-outstanding APB requester: one request in flight, registered one-cycle response.
module apb_param_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned NUM_SLV = 2,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   output logic                      rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic [NUM_SLV-1:0]        PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [ADDR_W-1:0]         PADDR,
   output logic [DATA_W-1:0]         PWDATA,
   input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
   input  logic [NUM_SLV-1:0]        PREADY,
   input  logic [NUM_SLV-1:0]        PSLVERR
);

   localparam int unsigned SEL_W = (clog2(NUM_SLV) > 1) ? clog2(NUM_SLV) : 1;
   localparam int unsigned CNT_W = (clog2(TIMEOUT + 1) > 1) ? clog2(TIMEOUT + 1) : 1;

   apb_state_e          r_state, w_state_nxt;
   logic [SEL_W-1:0]    w_req_idx;
   logic [NUM_SLV-1:0]  w_dec_psel;
   logic                w_dec_err;
   logic [NUM_SLV-1:0]  r_psel;
   logic [ADDR_W-1:0]   r_paddr;
   logic                r_pwrite;
   logic [DATA_W-1:0]   r_pwdata;
   logic [CNT_W-1:0]    r_wait_cnt;
   logic                w_sel_ready, w_sel_err;
   logic [DATA_W-1:0]   w_sel_rdata;
   logic                w_timeout_hit, w_complete;
   logic                w_accept, w_accept_ok, w_accept_bad;
   logic                r_derr_pend;
   logic                r_rsp_valid, r_rsp_err, r_rsp_timeout;
   logic [DATA_W-1:0]   r_rsp_rdata;

   assign w_req_idx = req_addr[ADDR_W-1 -: SEL_W];

   apb_addr_decoder #(
      .NUM_SLV (NUM_SLV),
      .SEL_W   (SEL_W)
   ) u_dec (
      .i_idx     (w_req_idx),
      .o_psel    (w_dec_psel),
      .o_dec_err (w_dec_err)
   );

   // Mux the selected completer's response; unselected completers never leak through.
   always_comb begin
      w_sel_ready = 1'b0;
      w_sel_err   = 1'b0;
      w_sel_rdata = '0;
      for (int k = 0; k < NUM_SLV; k++) begin
         if (r_psel[k]) begin
            w_sel_ready = PREADY[k];
            w_sel_err   = PSLVERR[k];
            w_sel_rdata = PRDATA[k*DATA_W +: DATA_W];
         end
      end
   end

   // The limit is reached in the ACCESS cycle that follows TIMEOUT wait states;
   // a PREADY seen in that same cycle still gives a normal completion.
   assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == CNT_W'(TIMEOUT));
   assign w_complete    = (r_state == ACCESS) && (w_sel_ready || w_timeout_hit);
   assign w_accept      = req_valid && req_ready;
   assign w_accept_ok   = w_accept && !w_dec_err;
   assign w_accept_bad  = w_accept && w_dec_err;

   // State register.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a decode-error request never leaves IDLE.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_accept_ok) w_state_nxt = SETUP;
         SETUP:   w_state_nxt = ACCESS;
         ACCESS:  if (w_complete) w_state_nxt = w_accept_ok ? SETUP : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM outputs; req_ready is held low while reset is asserted.
   always_comb begin
      PSEL      = (r_state != IDLE) ? r_psel : '0;
      PENABLE   = (r_state == ACCESS);
      req_ready = PRESETn && ((r_state == IDLE) || w_complete);
   end

   // Capture the accepted request; these hold their values while idle.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_psel   <= '0;
         r_paddr  <= '0;
         r_pwrite <= 1'b0;
         r_pwdata <= '0;
      end else if (w_accept_ok) begin
         r_psel   <= w_dec_psel;
         r_paddr  <= req_addr;
         r_pwrite <= req_write;
         r_pwdata <= req_wdata;
      end
   end

   // Wait-state counter, cleared on the way into ACCESS.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_wait_cnt <= '0;
      end else if (r_state == SETUP) begin
         r_wait_cnt <= '0;
      end else if ((r_state == ACCESS) && !w_complete) begin
         r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
   end

   // Response register. A decode error accepted in a completing ACCESS cycle
   // collides with that completion's pulse, so it is parked in r_derr_pend and
   // reported one cycle later; responses thus stay in acceptance order.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_derr_pend   <= 1'b0;
      end else begin
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_derr_pend   <= 1'b0;
         if (w_complete) begin
            r_rsp_valid <= 1'b1;
            r_derr_pend <= w_accept_bad;
            if (w_sel_ready) begin
               r_rsp_err   <= w_sel_err;
               r_rsp_rdata <= r_pwrite ? '0 : w_sel_rdata;
            end else begin
               r_rsp_err     <= 1'b1;
               r_rsp_timeout <= 1'b1;
            end
         end else if ((r_state == IDLE) && (r_derr_pend || w_accept_bad)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_derr_pend <= r_derr_pend && w_accept_bad;
         end
      end
   end

   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;
   assign PADDR       = r_paddr;
   assign PWRITE      = r_pwrite;
   assign PWDATA      = r_pwdata;

endmodule

// File: tb/tb_apb_param_master.sv
// Bench for apb_param_master (3 completers, 9-bit address, 8-bit data, timeout 8).
module tb_apb_param_master;

   localparam int NS   = 3;
   localparam int TO   = 8;
   localparam int MAXC = 6000;

   logic        PCLK, PRESETn;
   logic        req_valid, req_ready, req_write;
   logic [8:0]  req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid, rsp_err, rsp_timeout;
   logic [7:0]  rsp_rdata;
   logic [2:0]  PSEL;
   logic        PENABLE, PWRITE;
   logic [8:0]  PADDR;
   logic [7:0]  PWDATA;
   logic [23:0] PRDATA;
   logic [2:0]  PREADY, PSLVERR;

   apb_param_master #(
      .ADDR_W  (9),
      .DATA_W  (8),
      .NUM_SLV (NS),
      .TIMEOUT (TO)
   ) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // wait_n: ACCESS cycles the completer stalls before PREADY (> TO means never ready).
   typedef struct {
      logic [8:0] addr;
      logic       wr;
      logic [7:0] wdata;
      int         wait_n;
      logic [7:0] rdata;
      logic       slverr;
   } req_t;

   typedef struct {
      req_t       rq;
      logic [7:0] e_rdata;
      logic       e_err;
      logic       e_to;
      int         e_lat;
   } vec_t;

   // Expected bus/response schedule per cycle, filled in when a request is accepted.
   logic [2:0] m_psel  [MAXC];
   logic       m_pen   [MAXC];
   logic       m_rdy   [MAXC];
   logic       m_rv    [MAXC];
   logic [7:0] m_rd    [MAXC];
   logic       m_err   [MAXC];
   logic       m_to    [MAXC];
   logic [8:0] m_paddr [MAXC];
   logic       m_pwr   [MAXC];
   logic [7:0] m_pwd   [MAXC];
   // Completer behaviour per cycle for the selected completer.
   logic       d_rdy   [MAXC];
   logic       d_err   [MAXC];
   logic [7:0] d_rd    [MAXC];

   int   cyc, last_due, last_acc, last_rsp_cyc;
   logic [7:0] last_rsp_rd;
   logic last_rsp_err, last_rsp_to;
   int   rsp_cyc_q[$];
   req_t pend_q[$];
   int   n_tests, n_fail;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic init_model();
      for (int i = 0; i < MAXC; i++) begin
         m_psel[i] = '0;  m_pen[i] = 1'b0; m_rdy[i] = 1'b1;
         m_rv[i]   = 1'b0; m_rd[i] = '0;   m_err[i] = 1'b0; m_to[i] = 1'b0;
         m_paddr[i] = '0; m_pwr[i] = 1'b0; m_pwd[i] = '0;
         d_rdy[i] = 1'b0; d_err[i] = 1'b0; d_rd[i] = '0;
      end
      cyc      = 0;
      last_due = -1;
      last_acc = 0;
      pend_q.delete();
   endtask

   // Reference: request accepted in cycle a. Good index: SETUP in a+1, ACCESS a+2..a+2+w,
   // response a+3+w. Bad index: response a+1. Responses leave in order, one per cycle.
   task automatic schedule(input req_t r, input int a);
      int idx, w, nat, due;
      logic timed, eerr;
      logic [7:0] erd;
      idx      = int'(r.addr[8:7]);
      last_acc = a;
      timed    = 1'b0;
      if (idx >= NS) begin
         nat  = a + 1;
         erd  = 8'h00;
         eerr = 1'b1;
      end else begin
         timed = (r.wait_n > TO);
         w     = timed ? TO : r.wait_n;
         for (int i = a + 1; i <= a + 2 + w && i < MAXC; i++) m_psel[i] = 3'(1 << idx);
         for (int i = a + 2; i <= a + 2 + w && i < MAXC; i++) m_pen[i] = 1'b1;
         for (int i = a + 1; i <= a + 1 + w && i < MAXC; i++) m_rdy[i] = 1'b0;
         if (!timed && (a + 2 + w) < MAXC) begin
            d_rdy[a+2+w] = 1'b1;
            d_err[a+2+w] = r.slverr;
            d_rd[a+2+w]  = r.rdata;
         end
         for (int i = a + 1; i < MAXC; i++) begin
            m_paddr[i] = r.addr;
            m_pwr[i]   = r.wr;
            m_pwd[i]   = r.wdata;
         end
         nat  = a + 3 + w;
         erd  = (timed || r.wr) ? 8'h00 : r.rdata;
         eerr = timed ? 1'b1 : r.slverr;
      end
      due      = (nat > last_due) ? nat : last_due + 1;
      last_due = due;
      if (due < MAXC) begin
         m_rv[due]  = 1'b1;
         m_rd[due]  = erd;
         m_err[due] = eerr;
         m_to[due]  = timed;
      end
   endtask

   // One clock cycle: drive, check at the falling edge, advance past the rising edge.
   task automatic step();
      req_t rq;
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget: got %0d cycles, want < %0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      if (pend_q.size() > 0) begin
         req_valid = 1'b1;
         req_addr  = pend_q[0].addr;
         req_write = pend_q[0].wr;
         req_wdata = pend_q[0].wdata;
      end else begin
         req_valid = 1'b0;
         req_addr  = 9'($urandom);
         req_write = 1'($urandom);
         req_wdata = 8'($urandom);
      end
      PREADY  = 3'($urandom);
      PSLVERR = 3'($urandom);
      PRDATA  = 24'($urandom);
      for (int k = 0; k < NS; k++) begin
         if (m_psel[cyc][k]) begin
            PREADY[k] = d_rdy[cyc];
            if (d_rdy[cyc]) begin
               PSLVERR[k]       = d_err[cyc];
               PRDATA[k*8 +: 8] = d_rd[cyc];
            end
         end
      end
      @(negedge PCLK);
      chk("req_ready", 32'(req_ready), 32'(m_rdy[cyc]));
      chk("PSEL", 32'(PSEL), 32'(m_psel[cyc]));
      chk("PENABLE", 32'(PENABLE), 32'(m_pen[cyc]));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv[cyc]));
      if (m_rv[cyc]) begin
         chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rd[cyc]));
         chk("rsp_err", 32'(rsp_err), 32'(m_err[cyc]));
         chk("rsp_timeout", 32'(rsp_timeout), 32'(m_to[cyc]));
      end
      chk("PADDR", 32'(PADDR), 32'(m_paddr[cyc]));
      chk("PWRITE", 32'(PWRITE), 32'(m_pwr[cyc]));
      chk("PWDATA", 32'(PWDATA), 32'(m_pwd[cyc]));
      if (rsp_valid) begin
         last_rsp_cyc = cyc;
         last_rsp_rd  = rsp_rdata;
         last_rsp_err = rsp_err;
         last_rsp_to  = rsp_timeout;
         rsp_cyc_q.push_back(cyc);
      end
      if (req_valid && m_rdy[cyc]) begin
         rq = pend_q.pop_front();
         schedule(rq, cyc);
      end
      @(posedge PCLK);
      #1;
      cyc++;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) step();
   endtask

   task automatic run_drain();
      while (pend_q.size() > 0) step();
   endtask

   function automatic req_t mkr(input logic [8:0] addr, input logic wr, input logic [7:0] wdata,
                                input int wait_n, input logic [7:0] rdata, input logic slverr);
      req_t r;
      r.addr = addr; r.wr = wr; r.wdata = wdata;
      r.wait_n = wait_n; r.rdata = rdata; r.slverr = slverr;
      return r;
   endfunction

   function automatic vec_t mkv(input req_t rq, input logic [7:0] e_rdata, input logic e_err,
                                input logic e_to, input int e_lat);
      vec_t v;
      v.rq = rq; v.e_rdata = e_rdata; v.e_err = e_err; v.e_to = e_to; v.e_lat = e_lat;
      return v;
   endfunction

   function automatic req_t rand_req();
      int s;
      s = int'($urandom_range(0, 11));
      return mkr(9'($urandom), 1'($urandom), 8'($urandom),
                 (s < 6) ? (s % 4) : (s < 8) ? 8 : (s == 8) ? 7 : 12 + s,
                 8'($urandom), 1'($urandom));
   endfunction

   vec_t tv[8];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      PREADY = '0; PSLVERR = '0; PRDATA = '0;

      // Directed vectors: {request, completer behaviour} -> {rdata, err, timeout, latency}.
      tv[0] = mkv(mkr(9'h085, 1'b1, 8'hA5, 0, 8'h00, 1'b0), 8'h00, 1'b0, 1'b0, 3);
      tv[1] = mkv(mkr(9'h003, 1'b0, 8'h00, 2, 8'h3C, 1'b0), 8'h3C, 1'b0, 1'b0, 5);
      tv[2] = mkv(mkr(9'h180, 1'b0, 8'h00, 0, 8'hEE, 1'b0), 8'h00, 1'b1, 1'b0, 1);
      tv[3] = mkv(mkr(9'h000, 1'b0, 8'h00, 99, 8'hEE, 1'b0), 8'h00, 1'b1, 1'b1, 11);
      tv[4] = mkv(mkr(9'h000, 1'b0, 8'h00, 8, 8'h77, 1'b0), 8'h77, 1'b0, 1'b0, 11);
      tv[5] = mkv(mkr(9'h100, 1'b0, 8'h00, 1, 8'h5A, 1'b1), 8'h5A, 1'b1, 1'b0, 4);
      tv[6] = mkv(mkr(9'h07F, 1'b1, 8'h31, 0, 8'hEE, 1'b1), 8'h00, 1'b1, 1'b0, 3);
      tv[7] = mkv(mkr(9'h0C0, 1'b0, 8'h00, 7, 8'h81, 1'b0), 8'h81, 1'b0, 1'b0, 10);

      // Reset values.
      PRESETn = 1'b1;
      #1 PRESETn = 1'b0;
      #2;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_PSEL", 32'(PSEL), 32'h0);
      chk("rst_PENABLE", 32'(PENABLE), 32'h0);
      chk("rst_PWRITE", 32'(PWRITE), 32'h0);
      chk("rst_PADDR", 32'(PADDR), 32'h0);
      chk("rst_PWDATA", 32'(PWDATA), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst_rsp_timeout", 32'(rsp_timeout), 32'h0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      #1;
      chk("rel_req_ready", 32'(req_ready), 32'h1);
      @(posedge PCLK);
      #1;
      init_model();

      // Table-driven isolated transfers.
      for (int i = 0; i < 8; i++) begin
         last_rsp_cyc = -1;
         pend_q.push_back(tv[i].rq);
         run_drain();
         run_cycles(14);
         chk($sformatf("v%0d_latency", i),
             (last_rsp_cyc < 0) ? 32'hFFFF_FFFF : 32'(last_rsp_cyc - last_acc), 32'(tv[i].e_lat));
         chk($sformatf("v%0d_rdata", i), 32'(last_rsp_rd), 32'(tv[i].e_rdata));
         chk($sformatf("v%0d_err", i), 32'(last_rsp_err), 32'(tv[i].e_err));
         chk($sformatf("v%0d_timeout", i), 32'(last_rsp_to), 32'(tv[i].e_to));
      end

      // Back-to-back reads to completer 2: no IDLE gap, pulses two cycles apart.
      rsp_cyc_q.delete();
      pend_q.push_back(mkr(9'h100, 1'b0, 8'h00, 0, 8'h11, 1'b0));
      pend_q.push_back(mkr(9'h101, 1'b0, 8'h00, 0, 8'h22, 1'b0));
      run_drain();
      run_cycles(6);
      chk("b2b_rsp_count", 32'(rsp_cyc_q.size()), 32'd2);
      if (rsp_cyc_q.size() == 2) chk("b2b_rsp_gap", 32'(rsp_cyc_q[1] - rsp_cyc_q[0]), 32'd2);

      // Reset during an ACCESS wait state aborts the transfer without a response.
      pend_q.push_back(mkr(9'h045, 1'b1, 8'h99, 20, 8'h00, 1'b0));
      run_cycles(4);
      req_valid = 1'b0;
      #2 PRESETn = 1'b0;
      #1;
      chk("abort_PSEL", 32'(PSEL), 32'h0);
      chk("abort_PENABLE", 32'(PENABLE), 32'h0);
      chk("abort_req_ready", 32'(req_ready), 32'h0);
      chk("abort_PADDR", 32'(PADDR), 32'h0);
      chk("abort_PWDATA", 32'(PWDATA), 32'h0);
      chk("abort_PWRITE", 32'(PWRITE), 32'h0);
      repeat (2) begin
         @(negedge PCLK);
         chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
      end
      PRESETn = 1'b1;
      @(posedge PCLK);
      #1;
      init_model();
      last_rsp_cyc = -1;
      pend_q.push_back(mkr(9'h085, 1'b1, 8'h5C, 0, 8'h00, 1'b0));
      run_drain();
      run_cycles(6);
      chk("post_rst_latency",
          (last_rsp_cyc < 0) ? 32'hFFFF_FFFF : 32'(last_rsp_cyc - last_acc), 32'd3);
      chk("post_rst_err", 32'(last_rsp_err), 32'h0);

      // Randomised bursts against the schedule model.
      for (int it = 0; it < 40; it++) begin
         int n;
         n = int'($urandom_range(1, 4));
         for (int j = 0; j < n; j++) pend_q.push_back(rand_req());
         run_drain();
         run_cycles(int'($urandom_range(0, 3)));
      end
      run_cycles(15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
